// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl
// Brief    : Write-only HD44780 8-bit bus sequencer; runs the power-on init
//            sequence, then writes one byte per valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_ctrl #(
    parameter int unsigned T_POWERON = 750000,
    parameter int unsigned T_INIT1   = 205000,
    parameter int unsigned T_INIT2   = 5000,
    parameter int unsigned T_SETUP   = 2,
    parameter int unsigned T_PULSE   = 12,
    parameter int unsigned T_HOLD    = 1,
    parameter int unsigned T_CMD     = 2000,
    parameter int unsigned T_LONG    = 82000
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       REQ_VALID,
    input  logic       REQ_RS,
    input  logic [7:0] REQ_DATA,
    output logic       REQ_READY,
    output logic       INIT_DONE,
    output logic [7:0] LCD_DB,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW
);

    // Counter reload values: a state lasting N cycles loads N-1 and leaves at zero.
    localparam logic [19:0] C_POWERON  = 20'(T_POWERON - 1);
    localparam logic [19:0] C_INIT1    = 20'(T_INIT1 - 1);
    localparam logic [19:0] C_INIT2    = 20'(T_INIT2 - 1);
    localparam logic [19:0] C_SETUP    = 20'(T_SETUP - 1);
    localparam logic [19:0] C_PULSE    = 20'(T_PULSE - 1);
    localparam logic [19:0] C_HOLD     = 20'(T_HOLD - 1);
    localparam logic [19:0] C_CMD      = 20'(T_CMD - 1);
    localparam logic [19:0] C_LONG     = 20'(T_LONG - 1);
    localparam logic [2:0]  C_ROM_LAST = 3'd6;

    typedef enum logic [2:0] {
        S_PWR_WAIT = 3'd0,
        S_SETUP    = 3'd1,
        S_PULSE    = 3'd2,
        S_HOLD     = 3'd3,
        S_WAIT     = 3'd4,
        S_IDLE     = 3'd5
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [19:0] r_cnt, w_cnt_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic        r_e, w_e_nxt;
    logic        r_rs, w_rs_nxt;
    logic [7:0]  r_db, w_db_nxt;
    logic        r_ready, w_ready_nxt;
    logic        r_done, w_done_nxt;
    logic        w_cnt_zero;
    logic [19:0] w_wait_load;

    function automatic logic [7:0] f_init_rom(input logic [2:0] idx);
        case (idx)
            3'd4:    f_init_rom = 8'h06;
            3'd5:    f_init_rom = 8'h0C;
            3'd6:    f_init_rom = 8'h01;
            default: f_init_rom = 8'h38;
        endcase
    endfunction

    assign w_cnt_zero = (r_cnt == 20'd0);

    // The byte on the bus is still held, so the wait is chosen from it directly.
    always_comb begin
        w_wait_load = C_CMD;
        if (!r_done) begin
            case (r_idx)
                3'd0:       w_wait_load = C_INIT1;
                3'd1:       w_wait_load = C_INIT2;
                C_ROM_LAST: w_wait_load = C_LONG;
                default:    w_wait_load = C_CMD;
            endcase
        end else if (!r_rs && (r_db == 8'h01 || r_db == 8'h02 || r_db == 8'h03)) begin
            w_wait_load = C_LONG;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - 20'd1;
        w_idx_nxt   = r_idx;
        w_e_nxt     = r_e;
        w_rs_nxt    = r_rs;
        w_db_nxt    = r_db;
        w_ready_nxt = r_ready;
        w_done_nxt  = r_done;
        case (r_state)
            S_PWR_WAIT: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = C_SETUP;
                    w_idx_nxt   = 3'd0;
                    w_rs_nxt    = 1'b0;
                    w_db_nxt    = f_init_rom(3'd0);
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_PULSE;
                    w_cnt_nxt   = C_PULSE;
                    w_e_nxt     = 1'b1;
                end
            end
            S_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = C_HOLD;
                    w_e_nxt     = 1'b0;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = w_wait_load;
                end
            end
            S_WAIT: begin
                if (w_cnt_zero) begin
                    if (r_done || r_idx == C_ROM_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = r_cnt;
                        w_ready_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = C_SETUP;
                        w_idx_nxt   = r_idx + 3'd1;
                        w_db_nxt    = f_init_rom(r_idx + 3'd1);
                    end
                end
            end
            S_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (REQ_VALID && r_ready) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = C_SETUP;
                    w_ready_nxt = 1'b0;
                    w_rs_nxt    = REQ_RS;
                    w_db_nxt    = REQ_DATA;
                end
            end
            default: begin
                w_state_nxt = S_PWR_WAIT;
                w_cnt_nxt   = C_POWERON;
            end
        endcase
    end

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            r_state <= S_PWR_WAIT;
            r_cnt   <= C_POWERON;
            r_idx   <= 3'd0;
            r_e     <= 1'b0;
            r_rs    <= 1'b0;
            r_db    <= 8'h00;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_e     <= w_e_nxt;
            r_rs    <= w_rs_nxt;
            r_db    <= w_db_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign REQ_READY = r_ready;
    assign INIT_DONE = r_done;
    assign LCD_DB    = r_db;
    assign LCD_E     = r_e;
    assign LCD_RS    = r_rs;
    assign LCD_RW    = 1'b0;

endmodule
`default_nettype wire
